// File: rtl/top_level_led_pio.sv
// LED output PIO: Avalon-MM slave with static data, set/clear, per-bit
// one-shot pulses, per-bit blink and a pulse-done interrupt.
module top_level_led_pio #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PULSE_W   = 16,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int unsigned PSW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PSW-1:0] PRESC_MAX = PSW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        A_DATA      = 3'd0,
        A_PULSE_LEN = 3'd1,
        A_PULSE     = 3'd2,
        A_BLINK     = 3'd3,
        A_OUTSET    = 3'd4,
        A_OUTCLEAR  = 3'd5,
        A_DONE      = 3'd6,
        A_IRQ_MASK  = 3'd7
    } reg_addr_t;

    logic               wr;
    logic               rd;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH-1:0]   data_reg;
    logic [PULSE_W-1:0] pulse_len;
    logic [WIDTH-1:0]   busy;
    logic [PULSE_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0]   blink;
    logic [WIDTH-1:0]   done;
    logic [WIDTH-1:0]   irq_mask;
    logic [PSW-1:0]     presc;
    logic               phase;
    logic [WIDTH-1:0]   load;
    logic [WIDTH-1:0]   finish;
    logic [31:0]        rd_mux;
    logic               unused_wd;

    assign wr        = chipselect & ~write_n;
    assign rd        = chipselect & write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    assign out_port = data_reg ^ busy ^ (blink & {WIDTH{phase}});
    assign irq      = |(done & irq_mask);

    // Pulse loads and completions; a reload on the completing edge suppresses DONE
    always_comb begin
        load   = '0;
        finish = '0;
        if (wr && address == A_PULSE && pulse_len != '0)
            load = wd;
        for (int unsigned i = 0; i < WIDTH; i++)
            finish[i] = busy[i] && (cnt[i] == PULSE_W'(1)) && !load[i];
    end

    // Software-visible configuration registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg  <= '0;
            pulse_len <= '0;
            blink     <= '0;
            irq_mask  <= '0;
        end else if (wr) begin
            case (address)
                A_DATA:      data_reg  <= wd;
                A_PULSE_LEN: pulse_len <= writedata[PULSE_W-1:0];
                A_BLINK:     blink     <= wd;
                A_OUTSET:    data_reg  <= data_reg | wd;
                A_OUTCLEAR:  data_reg  <= data_reg & ~wd;
                A_IRQ_MASK:  irq_mask  <= wd;
                default:     ;
            endcase
        end
    end

    // Per-bit pulse down-counters and sticky DONE flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= '0;
            done <= '0;
            for (int unsigned i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (load[i]) begin
                    cnt[i]  <= pulse_len;
                    busy[i] <= 1'b1;
                end else if (busy[i]) begin
                    cnt[i] <= cnt[i] - PULSE_W'(1);
                    if (cnt[i] == PULSE_W'(1))
                        busy[i] <= 1'b0;
                end
            end
            done <= ((wr && address == A_DONE) ? '0 : done) | finish;
        end
    end

    // Free-running blink prescaler and phase
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc <= '0;
            phase <= 1'b0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            phase <= ~phase;
        end else begin
            presc <= presc + PSW'(1);
        end
    end

    // Read mux, zero-extended
    always_comb begin
        rd_mux = '0;
        case (address)
            A_DATA:      rd_mux[WIDTH-1:0]   = data_reg;
            A_PULSE_LEN: rd_mux[PULSE_W-1:0] = pulse_len;
            A_PULSE:     rd_mux[WIDTH-1:0]   = busy;
            A_BLINK:     rd_mux[WIDTH-1:0]   = blink;
            A_DONE:      rd_mux[WIDTH-1:0]   = done;
            A_IRQ_MASK:  rd_mux[WIDTH-1:0]   = irq_mask;
            default:     rd_mux = '0;
        endcase
    end

    // Registered read data, latency 1
    always_ff @(posedge clk) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd ? rd_mux : '0;
    end

endmodule

// File: tb/tb_top_level_led_pio.sv
// Directed bench for top_level_led_pio with a queue scoreboard of expected values.
module tb_top_level_led_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int tests_run = 0;
    int failed    = 0;
    logic [31:0] exp_q [$];

    top_level_led_pio #(
        .WIDTH(8),
        .PULSE_W(16),
        .BLINK_DIV(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        tests_run++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failed++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] e);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        expect_val(e);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        check(tag, readdata);
    endtask

    task automatic out_check(input string tag, input logic [7:0] e);
        expect_val({24'h0, e});
        check(tag, {24'h0, out_port});
    endtask

    task automatic irq_check(input string tag, input logic e);
        expect_val({31'h0, e});
        check(tag, {31'h0, irq});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        step();
        step();
        out_check("reset_out", 8'h00);
        irq_check("reset_irq", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       found;
        logic       p0;
        logic [7:0] prev;

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state and register readback
        do_reset();
        for (int a = 0; a < 8; a++)
            rd_check("reset_read", 3'(a), 32'h0);

        // DATA write and readback
        wr(3'd0, 32'hFFFF_FFA5);
        out_check("data_out", 8'hA5);
        rd_check("data_read", 3'd0, 32'h0000_00A5);

        // Set / clear
        wr(3'd4, 32'h0F);
        out_check("outset", 8'hAF);
        wr(3'd5, 32'h81);
        out_check("outclear", 8'h2E);
        rd_check("outset_read", 3'd4, 32'h0);
        rd_check("outclear_read", 3'd5, 32'h0);
        rd_check("data_after_setclr", 3'd0, 32'h2E);

        // Single pulse of length 3 with interrupt
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0001_0003);
        rd_check("pulse_len_read", 3'd1, 32'h3);
        wr(3'd7, 32'h01);
        wr(3'd2, 32'h01);
        out_check("pulse_c1", 8'h01);
        rd_check("busy_read", 3'd2, 32'h01);
        out_check("pulse_c2", 8'h01);
        step();
        out_check("pulse_c3", 8'h01);
        step();
        out_check("pulse_end", 8'h00);
        irq_check("irq_set", 1'b1);
        rd_check("done_read", 3'd6, 32'h01);
        rd_check("busy_idle", 3'd2, 32'h00);
        wr(3'd6, 32'h0);
        irq_check("irq_clear", 1'b0);
        rd_check("done_cleared", 3'd6, 32'h0);

        // Retrigger: length 4, second write two cycles in
        wr(3'd1, 32'h4);
        wr(3'd2, 32'h02);
        out_check("retrig_t0", 8'h02);
        step();
        out_check("retrig_t1", 8'h02);
        wr(3'd2, 32'h02);
        out_check("retrig_t2", 8'h02);
        step();
        out_check("retrig_t3", 8'h02);
        step();
        out_check("retrig_t4", 8'h02);
        rd_check("retrig_no_early_done", 3'd6, 32'h0);
        out_check("retrig_t5", 8'h02);
        step();
        out_check("retrig_t6_end", 8'h00);
        rd_check("retrig_done", 3'd6, 32'h02);
        irq_check("retrig_irq_masked", 1'b0);
        wr(3'd6, 32'h0);

        // Zero-length pulse is ignored
        wr(3'd1, 32'h0);
        wr(3'd2, 32'hFF);
        out_check("zero_len_out", 8'h00);
        rd_check("zero_len_busy", 3'd2, 32'h0);
        step();
        step();
        rd_check("zero_len_done", 3'd6, 32'h0);

        // Blink on bit 7, half-period 4
        wr(3'd3, 32'h80);
        rd_check("blink_read", 3'd3, 32'h80);
        prev  = out_port;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (out_port[7] != prev[7])
                found = 1'b1;
            else
                prev = out_port;
        end
        expect_val(32'h1);
        check("blink_toggle_seen", {31'h0, found});
        p0 = out_port[7];
        for (int k = 1; k < 12; k++) begin
            step();
            expect_val({31'h0, p0 ^ (((k / 4) % 2) == 1)});
            check("blink_bit7", {31'h0, out_port[7]});
            expect_val(32'h0);
            check("blink_others", {25'h0, out_port[6:0]});
        end

        // Reset during an active pulse and blink
        wr(3'd1, 32'd10);
        wr(3'd2, 32'h01);
        step();
        do_reset();
        wr(3'd7, 32'hFF);
        for (int k = 0; k < 12; k++)
            step();
        out_check("post_reset_out", 8'h00);
        irq_check("post_reset_irq", 1'b0);
        rd_check("post_reset_busy", 3'd2, 32'h0);
        rd_check("post_reset_done", 3'd6, 32'h0);
        rd_check("post_reset_blink", 3'd3, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
